// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and types for the VGA display path.
// Modules take these as parameter defaults so reduced rasters can be built.
package vga_pkg;
   localparam int H_VISIBLE   = 640;
   localparam int H_FP        = 16;
   localparam int H_SYNC      = 96;
   localparam int H_BP        = 48;
   localparam int V_VISIBLE   = 480;
   localparam int V_FP        = 10;
   localparam int V_SYNC      = 2;
   localparam int V_BP        = 33;
   localparam int ANIM_DIV    = 6;
   localparam int ANIM_FRAMES = 4;

   localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_START = H_VISIBLE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_VISIBLE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   typedef logic [9:0] coord_t;
   typedef logic [3:0] anim_t;
endpackage

// File: rtl/vga_anim_counter.sv
// Frame-rate animation index: advances once every ANIM_DIV frame_end pulses,
// wrapping at ANIM_FRAMES (a power of two, so the wrap is a mask).
module vga_anim_counter #(
   parameter int ANIM_DIV    = vga_pkg::ANIM_DIV,
   parameter int ANIM_FRAMES = vga_pkg::ANIM_FRAMES
) (
   input  logic       vga_clk,
   input  logic       reset,
   input  logic       frame_end,
   output logic [3:0] anim_frame
);
   import vga_pkg::*;

   localparam int    DIV_W      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam anim_t FRAME_MASK = anim_t'(ANIM_FRAMES - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   anim_t            anim_q, anim_d;

   always_comb begin
      div_cnt_d = div_cnt_q;
      anim_d    = anim_q;
      if (frame_end) begin
         if (div_cnt_q == DIV_W'(ANIM_DIV - 1)) begin
            div_cnt_d = '0;
            anim_d    = (anim_q + anim_t'(1)) & FRAME_MASK;
         end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         div_cnt_q <= '0;
         anim_q    <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
         anim_q    <= anim_d;
      end
   end

   assign anim_frame = anim_q;
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: free-running pixel/line counters, visible-area decode,
// one-cycle-delayed active-low syncs, frame-end pulse and animation index.
module vga_timing_gen #(
   parameter int H_VISIBLE   = vga_pkg::H_VISIBLE,
   parameter int H_FP        = vga_pkg::H_FP,
   parameter int H_SYNC      = vga_pkg::H_SYNC,
   parameter int H_BP        = vga_pkg::H_BP,
   parameter int V_VISIBLE   = vga_pkg::V_VISIBLE,
   parameter int V_FP        = vga_pkg::V_FP,
   parameter int V_SYNC      = vga_pkg::V_SYNC,
   parameter int V_BP        = vga_pkg::V_BP,
   parameter int ANIM_DIV    = vga_pkg::ANIM_DIV,
   parameter int ANIM_FRAMES = vga_pkg::ANIM_FRAMES
) (
   input  logic       vga_clk,
   input  logic       reset,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       frame_end,
   output logic [3:0] anim_frame
);
   import vga_pkg::*;

   localparam int H_LAST   = H_VISIBLE + H_FP + H_SYNC + H_BP - 1;
   localparam int V_LAST   = V_VISIBLE + V_FP + V_SYNC + V_BP - 1;
   localparam int HS_START = H_VISIBLE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   coord_t hc_q, hc_d, vc_q, vc_d;
   logic   hs_q, hs_d, vs_q, vs_d;
   logic   h_wrap, v_last;

   always_comb begin
      h_wrap = (hc_q == coord_t'(H_LAST));
      v_last = (vc_q == coord_t'(V_LAST));
      hc_d   = h_wrap ? '0 : hc_q + coord_t'(1);
      vc_d   = vc_q;
      if (h_wrap) begin
         vc_d = v_last ? '0 : vc_q + coord_t'(1);
      end
      hs_d = !((hc_q >= coord_t'(HS_START)) && (hc_q < coord_t'(HS_END)));
      vs_d = !((vc_q >= coord_t'(VS_START)) && (vc_q < coord_t'(VS_END)));
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         hc_q <= '0;
         vc_q <= '0;
         hs_q <= 1'b1;
         vs_q <= 1'b1;
      end else begin
         hc_q <= hc_d;
         vc_q <= vc_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
      end
   end

   // Masked during reset so a reset landing on the last pixel cannot advance animation.
   assign frame_end = h_wrap && v_last && !reset;
   assign DrawX     = hc_q;
   assign DrawY     = vc_q;
   assign blank     = (hc_q < coord_t'(H_VISIBLE)) && (vc_q < coord_t'(V_VISIBLE));
   assign hs        = hs_q;
   assign vs        = vs_q;

   vga_anim_counter #(
      .ANIM_DIV    (ANIM_DIV),
      .ANIM_FRAMES (ANIM_FRAMES)
   ) u_anim (
      .vga_clk    (vga_clk),
      .reset      (reset),
      .frame_end  (frame_end),
      .anim_frame (anim_frame)
   );
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size raster for reset/line timing, reduced 16x12 rasters
// for frame, animation and mid-frame reset behaviour.
module tb_vga_timing_gen;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [9:0] x0, y0, xs, ys, xa, ya;
   logic       b0, h0, v0, f0, bs, hs_s, vs_s, fs, ba, ha, va, fa;
   logic [3:0] a0, an_s, aa;
   int errors = 0;
   int checks = 0;

   vga_timing_gen dut (
      .vga_clk(clk), .reset(reset), .DrawX(x0), .DrawY(y0), .blank(b0),
      .hs(h0), .vs(v0), .frame_end(f0), .anim_frame(a0)
   );

   // Reduced raster: 16 pixels (hsync 10..12), 12 lines (vsync 8..9)
   vga_timing_gen #(
      .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
   ) dut_s (
      .vga_clk(clk), .reset(reset), .DrawX(xs), .DrawY(ys), .blank(bs),
      .hs(hs_s), .vs(vs_s), .frame_end(fs), .anim_frame(an_s)
   );

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
      .ANIM_DIV(1), .ANIM_FRAMES(2)
   ) dut_a (
      .vga_clk(clk), .reset(reset), .DrawX(xa), .DrawY(ya), .blank(ba),
      .hs(ha), .vs(va), .frame_end(fa), .anim_frame(aa)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
   endtask

   task automatic wait_fe(output bit ok);
      int k = 0;
      while (fs !== 1'b1 && k < 400) begin
         tick();
         k++;
      end
      ok = (fs === 1'b1);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_frame_end: frame_end=%b after %0d cycles, required 1", fs, k);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      checks += 7;
      if (x0 !== 10'd0) begin errors++; $display("FAIL reset_drawx: got %0d want 0", x0); end
      if (y0 !== 10'd0) begin errors++; $display("FAIL reset_drawy: got %0d want 0", y0); end
      if (b0 !== 1'b1) begin errors++; $display("FAIL reset_blank: got %b want 1", b0); end
      if (h0 !== 1'b1) begin errors++; $display("FAIL reset_hs: got %b want 1", h0); end
      if (v0 !== 1'b1) begin errors++; $display("FAIL reset_vs: got %b want 1", v0); end
      if (f0 !== 1'b0) begin errors++; $display("FAIL reset_frame_end: got %b want 0", f0); end
      if (a0 !== 4'd0) begin errors++; $display("FAIL reset_anim: got %0d want 0", a0); end
      $display("test_reset: DrawX=%0d DrawY=%0d hs=%b vs=%b", x0, y0, h0, v0);
      tick();
      checks++;
      if (x0 !== 10'd1) begin errors++; $display("FAIL reset_first_step: DrawX got %0d want 1", x0); end
   endtask

   task automatic test_line;
      int hs_low = 0;
      do_reset();
      for (int i = 0; i <= 800; i++) begin
         logic [9:0] ex, ey;
         logic eb, eh;
         ex = 10'(i % 800);
         ey = 10'(i / 800);
         eb = (i % 800) < 640;
         eh = !(i >= 657 && i <= 752);
         checks += 4;
         if (x0 !== ex) begin errors++; $display("FAIL line_drawx c=%0d: got %0d want %0d", i, x0, ex); end
         if (y0 !== ey) begin errors++; $display("FAIL line_drawy c=%0d: got %0d want %0d", i, y0, ey); end
         if (b0 !== eb) begin errors++; $display("FAIL line_blank c=%0d: got %b want %b", i, b0, eb); end
         if (h0 !== eh) begin errors++; $display("FAIL line_hs c=%0d: got %b want %b", i, h0, eh); end
         if (h0 === 1'b0) hs_low++;
         tick();
      end
      checks++;
      if (hs_low != 96) begin errors++; $display("FAIL line_hs_width: got %0d want 96", hs_low); end
      $display("test_line: hs low for %0d cycles", hs_low);
   endtask

   task automatic test_frame;
      int fe_cnt = 0;
      int fe_first = -1;
      int fe_second = -1;
      int vs_low = 0;
      do_reset();
      for (int c = 0; c <= 384; c++) begin
         int mx, my, px, py;
         logic ev, eh, ef;
         mx = c % 16;
         my = (c / 16) % 12;
         px = (c == 0) ? 0 : (c - 1) % 16;
         py = (c == 0) ? 0 : ((c - 1) / 16) % 12;
         ev = (c == 0) ? 1'b1 : !(py >= 8 && py <= 9);
         eh = (c == 0) ? 1'b1 : !(px >= 10 && px <= 12);
         ef = (mx == 15 && my == 11);
         checks += 5;
         if (xs !== 10'(mx)) begin errors++; $display("FAIL frame_drawx c=%0d: got %0d want %0d", c, xs, mx); end
         if (ys !== 10'(my)) begin errors++; $display("FAIL frame_drawy c=%0d: got %0d want %0d", c, ys, my); end
         if (vs_s !== ev) begin errors++; $display("FAIL frame_vs c=%0d: got %b want %b", c, vs_s, ev); end
         if (hs_s !== eh) begin errors++; $display("FAIL frame_hs c=%0d: got %b want %b", c, hs_s, eh); end
         if (fs !== ef) begin errors++; $display("FAIL frame_end c=%0d: got %b want %b", c, fs, ef); end
         if (fs === 1'b1) begin
            fe_cnt++;
            if (fe_first < 0) fe_first = c; else if (fe_second < 0) fe_second = c;
         end
         if (c >= 1 && c <= 192 && vs_s === 1'b0) vs_low++;
         tick();
      end
      checks += 3;
      if (fe_cnt != 2) begin errors++; $display("FAIL frame_end_count: got %0d want 2", fe_cnt); end
      if (fe_second - fe_first != 192) begin
         errors++; $display("FAIL frame_period: got %0d want 192", fe_second - fe_first);
      end
      if (vs_low != 32) begin errors++; $display("FAIL frame_vs_width: got %0d want 32", vs_low); end
      $display("test_frame: frame_end at %0d and %0d, vs low %0d cycles", fe_first, fe_second, vs_low);
   endtask

   task automatic test_anim;
      bit ok;
      do_reset();
      for (int f = 1; f <= 24; f++) begin
         wait_fe(ok);
         if (!ok) return;
         checks++;
         if (an_s !== 4'(((f - 1) / 6) % 4)) begin
            errors++; $display("FAIL anim_hold f=%0d: got %0d want %0d", f, an_s, ((f - 1) / 6) % 4);
         end
         tick();
         checks += 4;
         if (an_s !== 4'((f / 6) % 4)) begin
            errors++; $display("FAIL anim_step f=%0d: got %0d want %0d", f, an_s, (f / 6) % 4);
         end
         if (aa !== 4'(f % 2)) begin
            errors++; $display("FAIL anim_div1 f=%0d: got %0d want %0d", f, aa, f % 2);
         end
         if (xs !== 10'd0) begin errors++; $display("FAIL anim_drawx f=%0d: got %0d want 0", f, xs); end
         if (ys !== 10'd0) begin errors++; $display("FAIL anim_drawy f=%0d: got %0d want 0", f, ys); end
         $display("test_anim: frame_end #%0d anim_frame=%0d alt=%0d", f, an_s, aa);
      end
   endtask

   task automatic test_mid_reset;
      bit ok;
      int k = 0;
      do_reset();
      for (int f = 0; f < 7; f++) begin
         wait_fe(ok);
         if (!ok) return;
         tick();
      end
      while (!(xs === 10'd11 && ys === 10'd9) && k < 400) begin
         tick();
         k++;
      end
      checks += 3;
      if (k >= 400) begin errors++; $display("FAIL mid_reach: position (%0d,%0d) want (11,9)", xs, ys); end
      if (hs_s !== 1'b0 || vs_s !== 1'b0) begin
         errors++; $display("FAIL mid_pre_sync: hs=%b vs=%b want 0 0", hs_s, vs_s);
      end
      if (an_s !== 4'd1) begin errors++; $display("FAIL mid_pre_anim: got %0d want 1", an_s); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks += 6;
      if (xs !== 10'd0) begin errors++; $display("FAIL mid_drawx: got %0d want 0", xs); end
      if (ys !== 10'd0) begin errors++; $display("FAIL mid_drawy: got %0d want 0", ys); end
      if (hs_s !== 1'b1) begin errors++; $display("FAIL mid_hs: got %b want 1", hs_s); end
      if (vs_s !== 1'b1) begin errors++; $display("FAIL mid_vs: got %b want 1", vs_s); end
      if (an_s !== 4'd0) begin errors++; $display("FAIL mid_anim: got %0d want 0", an_s); end
      if (fs !== 1'b0) begin errors++; $display("FAIL mid_frame_end: got %b want 0", fs); end
      $display("test_mid_reset: after reset DrawX=%0d DrawY=%0d anim=%0d", xs, ys, an_s);
      // A cleared divider takes a full ANIM_DIV frames to step again
      for (int f = 1; f <= 6; f++) begin
         wait_fe(ok);
         if (!ok) return;
         tick();
         checks++;
         if (an_s !== ((f == 6) ? 4'd1 : 4'd0)) begin
            errors++; $display("FAIL mid_div_cleared f=%0d: got %0d want %0d", f, an_s, (f == 6) ? 1 : 0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_frame();
      test_anim();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
